// File: rtl/vga_dls_supervisor.sv
// ----------------------------------------------------------------------------
// vga_dls_supervisor
//   Supervises a lockstep (dual-lockstep) VGA core pair. A persistent
//   DLS_ERROR mismatch is treated as a fault: both cores are held in reset
//   and the display is blanked for a fixed pulse, followed by a short settle
//   window. After MAX_RETRY recoveries the next fault locks the pair out
//   until software clears it. Short mismatch bursts are counted as glitches.
//   An AHB-Lite slave exposes status, counters and a control register.
//
// Parameters
//   PERSIST     consecutive DLS_ERROR cycles that declare a fault (1..15)
//   RST_CYCLES  recovery reset pulse length in HCLK cycles (2..255)
//   MAX_RETRY   recoveries allowed before lock-out (1..15)
//
// Ports
//   HCLK, HRESETn             clock, asynchronous active-low reset
//   HSEL, HREADY, HWRITE,
//   HTRANS, HADDR, HWDATA     AHB-Lite slave inputs
//   HRDATA, HREADYOUT         AHB-Lite read data, always-ready
//   DLS_ERROR                 registered mismatch flag from the core pair
//   CORE_RSTn                 active-low reset to both VGA cores (registered)
//   BLANK                     forces displayed RGB to 0 (registered)
//   IRQ                       level interrupt = enable & pending
//
// Register map (word offsets)
//   0x0 STATUS RO  [2:0] state, [7:4] retry, [8] IRQ pending
//   0x4 COUNT  RO  [15:0] faults, [31:16] glitches
//   0x8 CTRL       [0] IRQ enable (RW); [1] clear, [2] force, [3] IRQ ack
//                  (write-1 pulses, read as 0)
//   0xC reserved, reads 0
//
// Build option
//   DLS_SUPERVISOR_GLITCH_CNT_EN  when defined, the glitch counter exists;
//   otherwise COUNT[31:16] reads 0. FSM behaviour is unaffected.
// ----------------------------------------------------------------------------
module vga_dls_supervisor #(
  parameter int unsigned PERSIST    = 4,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        DLS_ERROR,
  output logic        CORE_RSTn,
  output logic        BLANK,
  output logic        IRQ
);

  localparam int unsigned ST_W          = 3;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned RETRY_W       = 4;
  localparam int unsigned PERSIST_W     = 4;
  localparam int unsigned TMR_W         = 8;
  localparam int unsigned SETTLE_CYCLES = 2;

  localparam logic [ST_W-1:0] ST_RUN     = 3'd0;
  localparam logic [ST_W-1:0] ST_SUSPECT = 3'd1;
  localparam logic [ST_W-1:0] ST_RECOVER = 3'd2;
  localparam logic [ST_W-1:0] ST_SETTLE  = 3'd3;
  localparam logic [ST_W-1:0] ST_LOCKED  = 3'd4;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // --------------------------------------------------------------------------
  // AHB-Lite address phase capture
  // --------------------------------------------------------------------------
  logic       addr_valid_c;
  logic       wr_q;
  logic       rd_q;
  logic [1:0] addr_q;

  assign addr_valid_c = HSEL & HREADY & HTRANS[1];
  assign HREADYOUT    = 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 2'd0;
    end else if (HREADY) begin
      wr_q <= addr_valid_c & HWRITE;
      rd_q <= addr_valid_c & ~HWRITE;
      if (addr_valid_c) begin
        addr_q <= HADDR[3:2];
      end
    end
  end

  // CTRL write pulses act at the edge that ends the data phase
  logic ctrl_wr_c;
  logic clear_c;
  logic force_c;
  logic irq_ack_c;

  assign ctrl_wr_c = wr_q & (addr_q == REG_CTRL);
  assign clear_c   = ctrl_wr_c & HWDATA[1];
  assign force_c   = ctrl_wr_c & HWDATA[2];
  assign irq_ack_c = ctrl_wr_c & HWDATA[3];

  // --------------------------------------------------------------------------
  // Supervisor FSM
  // --------------------------------------------------------------------------
  logic [ST_W-1:0]      state_q,   state_d;
  logic [PERSIST_W-1:0] persist_q, persist_d;
  logic [TMR_W-1:0]     tmr_q,     tmr_d;
  logic [RETRY_W-1:0]   retry_q,   retry_d;
  logic                 fault_evt_c;
  logic                 glitch_evt_c;
  logic                 core_rstn_q;
  logic                 blank_q;

  // State register; the pin outputs follow the next state so they are
  // already asserted in the first cycle of the qualifying state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_RUN;
      persist_q   <= '0;
      tmr_q       <= '0;
      retry_q     <= '0;
      core_rstn_q <= 1'b1;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      persist_q   <= persist_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      core_rstn_q <= ~((state_d == ST_RECOVER) | (state_d == ST_LOCKED));
      blank_q     <= (state_d == ST_RECOVER) | (state_d == ST_SETTLE) |
                     (state_d == ST_LOCKED);
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    persist_d    = persist_q;
    tmr_d        = tmr_q;
    retry_d      = retry_q;
    fault_evt_c  = 1'b0;
    glitch_evt_c = 1'b0;

    case (state_q)
      ST_RUN: begin
        persist_d = '0;
        if (force_c || (DLS_ERROR && (PERSIST == 1))) begin
          fault_evt_c = 1'b1;
        end else if (DLS_ERROR) begin
          state_d   = ST_SUSPECT;
          persist_d = PERSIST_W'(1);
        end
      end
      ST_SUSPECT: begin
        if (force_c) begin
          fault_evt_c = 1'b1;
        end else if (!DLS_ERROR) begin
          state_d      = ST_RUN;
          persist_d    = '0;
          glitch_evt_c = 1'b1;
        end else if (persist_q == PERSIST_W'(PERSIST - 1)) begin
          fault_evt_c = 1'b1;
        end else begin
          persist_d = persist_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        if (tmr_q == TMR_W'(RST_CYCLES - 1)) begin
          state_d = ST_SETTLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        // DLS_ERROR is not looked at while the cores come out of reset
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d   = ST_RUN;
        persist_d = '0;
        tmr_d     = '0;
      end
    endcase

    // Fault path: either another recovery or lock-out once retries run out
    if (fault_evt_c) begin
      persist_d = '0;
      tmr_d     = '0;
      if (retry_q == RETRY_W'(MAX_RETRY)) begin
        state_d = ST_LOCKED;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = ST_RECOVER;
      end
    end

    // Software clear re-arms the retry budget and releases a lock-out
    if (clear_c) begin
      retry_d = '0;
      if (state_q == ST_LOCKED) begin
        state_d = ST_RUN;
        tmr_d   = '0;
      end
    end
  end

  assign CORE_RSTn = core_rstn_q;
  assign BLANK     = blank_q;

  // --------------------------------------------------------------------------
  // Saturating fault counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] fault_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fault_q <= '0;
    end else if (fault_evt_c && (fault_q != '1)) begin
      fault_q <= fault_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional saturating glitch counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] glitch_rd_c;

`ifdef DLS_SUPERVISOR_GLITCH_CNT_EN
  logic [CNT_W-1:0] glitch_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      glitch_q <= '0;
    end else if (glitch_evt_c && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_rd_c = glitch_q;
`else
  logic unused_glitch_c;

  assign unused_glitch_c = glitch_evt_c;
  assign glitch_rd_c     = '0;
`endif

  // --------------------------------------------------------------------------
  // Interrupt enable / pending; a new fault wins over a same-cycle ack
  // --------------------------------------------------------------------------
  logic irq_en_q;
  logic irq_pend_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      if (ctrl_wr_c) begin
        irq_en_q <= HWDATA[0];
      end
      if (fault_evt_c) begin
        irq_pend_q <= 1'b1;
      end else if (irq_ack_c) begin
        irq_pend_q <= 1'b0;
      end
    end
  end

  assign IRQ = irq_en_q & irq_pend_q;

  // --------------------------------------------------------------------------
  // Read mux, driven from the captured address during the data phase
  // --------------------------------------------------------------------------
  logic [31:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    if (rd_q) begin
      case (addr_q)
        REG_STATUS: rdata_c = {23'd0, irq_pend_q, retry_q, 1'b0, state_q};
        REG_COUNT:  rdata_c = {glitch_rd_c, fault_q};
        REG_CTRL:   rdata_c = {31'd0, irq_en_q};
        default:    rdata_c = '0;
      endcase
    end
  end

  assign HRDATA = rdata_c;

  // Address/data bits outside the decoded register window
  logic unused_bus_c;

  assign unused_bus_c = &{1'b0, HADDR[31:4], HADDR[1:0], HWDATA[31:4], HTRANS[0]};

endmodule

// File: tb/tb_vga_dls_supervisor.sv
// ----------------------------------------------------------------------------
// tb_vga_dls_supervisor
//   Self-checking bench for vga_dls_supervisor. A behavioural model tracks
//   the supervisor at the level of its rules (mode, cycles left in a pulse,
//   counters) and is stepped once per clock alongside the DUT.
// ----------------------------------------------------------------------------
module tb_vga_dls_supervisor;

  localparam int unsigned PERSIST    = 4;
  localparam int unsigned RST_CYCLES = 16;
  localparam int unsigned MAX_RETRY  = 3;

  localparam int M_RUN     = 0;
  localparam int M_SUSPECT = 1;
  localparam int M_RECOVER = 2;
  localparam int M_SETTLE  = 3;
  localparam int M_LOCKED  = 4;

`ifdef DLS_SUPERVISOR_GLITCH_CNT_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        DLS_ERROR;
  logic        CORE_RSTn;
  logic        BLANK;
  logic        IRQ;

  vga_dls_supervisor #(
    .PERSIST    (PERSIST),
    .RST_CYCLES (RST_CYCLES),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADY),
    .HWRITE    (HWRITE),
    .HTRANS    (HTRANS),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .DLS_ERROR (DLS_ERROR),
    .CORE_RSTn (CORE_RSTn),
    .BLANK     (BLANK),
    .IRQ       (IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int m_mode;
  int m_persist;
  int m_left;
  int m_retry;
  int m_faults;
  int m_glitch;
  bit m_en;
  bit m_pend;

  function automatic void model_reset();
    m_mode = M_RUN; m_persist = 0; m_left = 0; m_retry = 0;
    m_faults = 0; m_glitch = 0; m_en = 1'b0; m_pend = 1'b0;
  endfunction

  function automatic void model_step(input bit dls, input bit wr, input logic [31:0] wd);
    bit fault;
    bit clr;
    bit frc;
    bit ack;
    int mode0;
    fault = 1'b0;
    mode0 = m_mode;
    clr = wr & wd[1];
    frc = wr & wd[2];
    ack = wr & wd[3];
    case (m_mode)
      M_RUN: begin
        if (frc) fault = 1'b1;
        else if (dls) begin
          m_persist = 1;
          if (m_persist >= PERSIST) fault = 1'b1;
          else m_mode = M_SUSPECT;
        end
      end
      M_SUSPECT: begin
        if (frc) fault = 1'b1;
        else if (!dls) begin
          m_mode = M_RUN;
          if (m_glitch < 65535) m_glitch++;
        end else begin
          m_persist++;
          if (m_persist >= PERSIST) fault = 1'b1;
        end
      end
      M_RECOVER: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_SETTLE; m_left = 2; end
      end
      M_SETTLE: begin
        m_left--;
        if (m_left == 0) m_mode = M_RUN;
      end
      default: ;
    endcase
    if (wr) m_en = wd[0];
    if (ack) m_pend = 1'b0;
    if (fault) begin
      if (m_faults < 65535) m_faults++;
      m_pend = 1'b1;
      if (m_retry == MAX_RETRY) m_mode = M_LOCKED;
      else begin m_retry++; m_mode = M_RECOVER; m_left = RST_CYCLES; end
    end
    if (clr) begin
      m_retry = 0;
      if (mode0 == M_LOCKED) m_mode = M_RUN;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return {23'd0, m_pend, 4'(m_retry), 1'b0, 3'(m_mode)};
      4'h4:    return {(GLITCH_EN ? 16'(m_glitch) : 16'h0), 16'(m_faults)};
      4'h8:    return {31'd0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // One clock of stimulus: finishes the previous transfer's data phase,
  // starts an optional new address phase, then checks the pin outputs.
  // op: 0 idle, 1 write, 2 read. Called and returns at a falling edge.
  // --------------------------------------------------------------------------
  int          dp_op;
  logic [3:0]  dp_addr;
  logic [31:0] dp_wdata;
  logic [31:0] last_rdata;

  task automatic step(input logic dls, input int op, input logic [3:0] addr, input logic [31:0] wdata);
    if (dp_op == 2) begin
      last_rdata = HRDATA;
      check("hrdata", HRDATA, model_read(dp_addr));
    end
    HWDATA    = dp_wdata;
    DLS_ERROR = dls;
    HSEL      = (op != 0);
    HTRANS    = (op != 0) ? 2'b10 : 2'b00;
    HWRITE    = (op == 1);
    HADDR     = {28'h0, addr};
    @(posedge HCLK);
    model_step(dls, (dp_op == 1) && (dp_addr == 4'h8), dp_wdata);
    dp_op    = op;
    dp_addr  = addr;
    dp_wdata = wdata;
    @(negedge HCLK);
    check("core_rstn", 32'(CORE_RSTn), 32'(!(m_mode == M_RECOVER || m_mode == M_LOCKED)));
    check("blank", 32'(BLANK), 32'(m_mode == M_RECOVER || m_mode == M_SETTLE || m_mode == M_LOCKED));
    check("irq", 32'(IRQ), 32'(m_en & m_pend));
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    step(1'b0, 2, addr, 32'h0);
    step(1'b0, 0, 4'h0, 32'h0);
    data = last_rdata;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    step(1'b0, 1, addr, data);
    step(1'b0, 0, 4'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 4'h0, 32'h0);
  endtask

  // Asynchronous reset, checked while it is still asserted
  task automatic do_reset();
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; DLS_ERROR = 1'b0;
    dp_op = 0; dp_addr = 4'h0; dp_wdata = 32'h0;
    model_reset();
    #2;
    check("rst_core_rstn", 32'(CORE_RSTn), 32'h1);
    check("rst_blank", 32'(BLANK), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  typedef struct {
    int   burst;
    int   exp_state;
    int   exp_faults;
    int   exp_glitch;
    logic exp_core;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rd;
    int low_cnt;
    int blank_cnt;
    int burst;
    logic dls;
    int op;
    int r;
    logic [3:0] addr;
    logic [31:0] wd;

    n_pass = 0; n_total = 0;
    HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HTRANS = 2'b00;
    HADDR = 32'h0; HWDATA = 32'h0; DLS_ERROR = 1'b0;
    dp_op = 0; dp_addr = 4'h0; dp_wdata = 32'h0; last_rdata = 32'h0;
    model_reset();
    @(negedge HCLK);
    do_reset();
    check("hreadyout", 32'(HREADYOUT), 32'h1);

    // DLS_ERROR burst length -> outcome after one quiet cycle
    vecs[0] = '{1, M_RUN,     0, 1, 1'b1};
    vecs[1] = '{3, M_RUN,     0, 1, 1'b1};
    vecs[2] = '{4, M_RECOVER, 1, 0, 1'b0};
    vecs[3] = '{6, M_RECOVER, 1, 0, 1'b0};
    vecs[4] = '{0, M_RUN,     0, 0, 1'b1};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].burst; i++) step(1'b1, 0, 4'h0, 32'h0);
      step(1'b0, 0, 4'h0, 32'h0);
      check("vec_core_rstn", 32'(CORE_RSTn), 32'(vecs[v].exp_core));
      bus_read(4'h0, rd);
      check("vec_state", 32'(rd[2:0]), 32'(vecs[v].exp_state));
      bus_read(4'h4, rd);
      check("vec_faults", 32'(rd[15:0]), 32'(vecs[v].exp_faults));
      check("vec_glitches", 32'(rd[31:16]), GLITCH_EN ? 32'(vecs[v].exp_glitch) : 32'h0);
    end

    // Recovery pulse widths and interrupt
    do_reset();
    bus_write(4'h8, 32'h1);
    low_cnt = 0; blank_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      step((i < 4) ? 1'b1 : 1'b0, 0, 4'h0, 32'h0);
      if (!CORE_RSTn) low_cnt++;
      if (BLANK) blank_cnt++;
      if (i == 3) check("s2_irq_on_fault", 32'(IRQ), 32'h1);
    end
    check("s2_core_low_cycles", 32'(low_cnt), 32'd16);
    check("s2_blank_cycles", 32'(blank_cnt), 32'd18);
    bus_read(4'h0, rd);
    check("s2_status", rd, 32'h110);
    check("s2_irq_level", 32'(IRQ), 32'h1);

    // Retries exhausted -> lock-out, software clear
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 0, 4'h0, 32'h0);
      idle(25);
    end
    bus_read(4'h0, rd);
    check("s3_locked_state", 32'(rd[2:0]), 32'd4);
    check("s3_locked_retry", 32'(rd[7:4]), 32'd3);
    check("s3_locked_core", 32'(CORE_RSTn), 32'h0);
    bus_write(4'h8, 32'h2);
    check("s3_clear_core", 32'(CORE_RSTn), 32'h1);
    bus_read(4'h0, rd);
    check("s3_after_clear", rd, 32'h100);

    // Software force, ignored while recovering
    do_reset();
    bus_write(4'h8, 32'h4);
    check("s4_force_core", 32'(CORE_RSTn), 32'h0);
    bus_read(4'h4, rd);
    check("s4_faults_1", 32'(rd[15:0]), 32'd1);
    bus_write(4'h8, 32'h4);
    bus_read(4'h4, rd);
    check("s4_faults_still_1", 32'(rd[15:0]), 32'd1);
    bus_read(4'h0, rd);
    check("s4_status", 32'(rd[7:0]), 32'h12);
    idle(20);

    // Fault counter saturation, then reset in the middle of a recovery
    do_reset();
    force dut.fault_q = 16'hFFFE;
    #1;
    release dut.fault_q;
    m_faults = 65534;
    bus_read(4'h4, rd);
    check("s5_preload", 32'(rd[15:0]), 32'hFFFE);
    bus_write(4'h8, 32'h4);
    idle(20);
    bus_read(4'h4, rd);
    check("s5_faults_max", 32'(rd[15:0]), 32'hFFFF);
    bus_write(4'h8, 32'h4);
    bus_read(4'h4, rd);
    check("s5_faults_sat", 32'(rd[15:0]), 32'hFFFF);
    idle(3);
    check("s5_mid_recover_core", 32'(CORE_RSTn), 32'h0);
    do_reset();
    bus_read(4'h0, rd);
    check("s5_status_zero", rd, 32'h0);
    bus_read(4'h4, rd);
    check("s5_count_zero", rd, 32'h0);
    bus_read(4'h8, rd);
    check("s5_ctrl_zero", rd, 32'h0);
    idle(5);

    // Randomised traffic against the model
    do_reset();
    bus_write(4'h8, 32'h1);
    burst = 0;
    for (int c = 0; c < 2000; c++) begin
      dls = 1'b0;
      if (burst > 0) begin
        dls = 1'b1;
        burst--;
      end else if ($urandom_range(0, 5) == 0) begin
        dls = 1'b1;
        burst = int'($urandom_range(0, 6));
      end
      op = 0; addr = 4'h0; wd = 32'h0;
      r = int'($urandom_range(0, 99));
      if (m_mode == M_LOCKED && r < 15) begin
        op = 1; addr = 4'h8; wd = 32'h2 | 32'($urandom_range(0, 1));
      end else if (r < 10) begin
        op = 2; addr = {2'($urandom_range(0, 3)), 2'b00};
      end else if (r < 13) begin
        op = 1; addr = 4'h8; wd = 32'($urandom_range(0, 15));
      end else if (r < 15) begin
        op = 1; addr = {2'($urandom_range(0, 3)), 2'b00};
        if (addr == 4'h8) addr = 4'hC;
        wd = $urandom;
      end
      step(dls, op, addr, wd);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
